// File: rtl/ccff_bitstream_loader.sv
`default_nettype none
// ============================================================================
// Module   : ccff_bitstream_loader
// Brief    : Serializes a valid/ready bitstream MSB-first into the fabric
//            configuration chain, with a single-bit chain-length probe mode.
// Revision : 1.0  initial release
// ============================================================================
module ccff_bitstream_loader #(
    parameter int BITSTREAM_SIZE = 65656,
    parameter int WORD_WIDTH     = 32,
    parameter int TAIL_SLACK     = 16,
    parameter int CNT_W          = $clog2(BITSTREAM_SIZE + TAIL_SLACK + 1)
) (
    input  logic                  i_prog_clk,
    input  logic                  i_prog_reset,
    input  logic                  i_start,
    input  logic                  i_probe_mode,
    input  logic [WORD_WIDTH-1:0] i_bs_data,
    input  logic                  i_bs_valid,
    output logic                  o_bs_ready,
    output logic                  o_ccff_head,
    input  logic                  i_ccff_tail,
    output logic                  o_prog_clk_en,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic [CNT_W-1:0]      o_bit_count
);

    localparam logic [CNT_W-1:0]      c_SIZE       = CNT_W'(BITSTREAM_SIZE);
    localparam logic [CNT_W-1:0]      c_LAST       = CNT_W'(BITSTREAM_SIZE - 1);
    localparam logic [CNT_W-1:0]      c_TIMEOUT    = CNT_W'(BITSTREAM_SIZE + TAIL_SLACK);
    localparam logic [CNT_W-1:0]      c_WORD       = CNT_W'(WORD_WIDTH);
    localparam logic [CNT_W-1:0]      c_ONE        = CNT_W'(1);
    localparam logic [WORD_WIDTH-1:0] c_PROBE_SEED = {1'b1, {(WORD_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SHIFT  = 3'd2,
        S_PROBE  = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t                r_state;
    logic [WORD_WIDTH-1:0] r_shreg;
    logic [CNT_W-1:0]      r_bits_left;
    logic [CNT_W-1:0]      r_bit_count;
    logic                  r_en;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;

    logic                  w_word_end;
    logic                  w_final;
    logic [CNT_W-1:0]      w_cnt_inc;
    logic [CNT_W-1:0]      w_rem;
    logic [CNT_W-1:0]      w_bits_new;

    assign w_word_end = (r_bits_left == c_ONE);
    assign w_final    = (r_bit_count == c_LAST);
    assign w_cnt_inc  = r_bit_count + c_ONE;

    // Bits still owed to the chain once the word being accepted starts shifting.
    assign w_rem      = c_SIZE - ((r_state == S_SHIFT) ? w_cnt_inc : r_bit_count);
    assign w_bits_new = (w_rem > c_WORD) ? c_WORD : w_rem;

    // Decoded from registered state only, so bs_valid never loops back to bs_ready.
    assign o_bs_ready = (r_state == S_LOAD) ||
                        ((r_state == S_SHIFT) && w_word_end && !w_final);

    assign o_ccff_head   = r_shreg[WORD_WIDTH-1];
    assign o_prog_clk_en = r_en;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_error       = r_error;
    assign o_bit_count   = r_bit_count;

    always_ff @(posedge i_prog_clk) begin
        if (i_prog_reset) begin
            r_state     <= S_IDLE;
            r_shreg     <= '0;
            r_bits_left <= '0;
            r_bit_count <= '0;
            r_en        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_done      <= 1'b0;
                        r_error     <= 1'b0;
                        r_bit_count <= '0;
                        r_busy      <= 1'b1;
                        if (i_probe_mode) begin
                            r_state <= S_PROBE;
                            r_shreg <= c_PROBE_SEED;
                            r_en    <= 1'b1;
                        end else begin
                            r_state <= S_LOAD;
                            r_shreg <= '0;
                            r_en    <= 1'b0;
                        end
                    end
                end

                S_LOAD: begin
                    if (i_bs_valid) begin
                        r_shreg     <= i_bs_data;
                        r_bits_left <= w_bits_new;
                        r_en        <= 1'b1;
                        r_state     <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    r_bit_count <= w_cnt_inc;
                    if (!w_word_end) begin
                        r_shreg     <= r_shreg << 1;
                        r_bits_left <= r_bits_left - c_ONE;
                    end else if (w_final) begin
                        r_shreg <= '0;
                        r_en    <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_FINISH;
                    end else if (i_bs_valid) begin
                        // Back-to-back word: its MSB goes out on the very next edge.
                        r_shreg     <= i_bs_data;
                        r_bits_left <= w_bits_new;
                    end else begin
                        r_shreg <= '0;
                        r_en    <= 1'b0;
                        r_state <= S_LOAD;
                    end
                end

                S_PROBE: begin
                    r_bit_count <= w_cnt_inc;
                    r_shreg     <= r_shreg << 1;
                    if (i_ccff_tail) begin
                        r_shreg <= '0;
                        r_en    <= 1'b0;
                        r_state <= S_FINISH;
                        if (r_bit_count == c_SIZE) begin
                            r_done <= 1'b1;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end else if (w_cnt_inc == c_TIMEOUT) begin
                        r_shreg <= '0;
                        r_en    <= 1'b0;
                        r_error <= 1'b1;
                        r_state <= S_FINISH;
                    end
                end

                S_FINISH: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ccff_bitstream_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ccff_bitstream_loader
// Brief    : Directed bench for ccff_bitstream_loader with a gated-clock chain model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ccff_bitstream_loader;

    localparam int SIZE  = 10;
    localparam int WW    = 4;
    localparam int SLACK = 4;
    localparam int CW    = $clog2(SIZE + SLACK + 1);

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic          probe = 1'b0;
    logic          valid = 1'b0;
    logic [WW-1:0] data  = '0;
    logic          tail;
    logic          ready, head, en, busy, done, err;
    logic [CW-1:0] cnt;

    logic [9:0]    chain    = '0;
    logic [9:0]    head_log = '0;
    logic [3:0]    n_len    = 4'd10;
    logic          stuck0   = 1'b0;
    logic          mon_on   = 1'b0;
    logic          prev_frz = 1'b0;
    logic [CW-1:0] prev_cnt = '0;
    int            cyc = 0, xfers = 0, en_cnt = 0, frz_cnt = 0, frz_viol = 0;
    int            errors = 0, checks = 0;
    logic [WW-1:0] words [3];

    ccff_bitstream_loader #(
        .BITSTREAM_SIZE (SIZE),
        .WORD_WIDTH     (WW),
        .TAIL_SLACK     (SLACK),
        .CNT_W          (CW)
    ) dut (
        .i_prog_clk    (clk),
        .i_prog_reset  (rst),
        .i_start       (start),
        .i_probe_mode  (probe),
        .i_bs_data     (data),
        .i_bs_valid    (valid),
        .o_bs_ready    (ready),
        .o_ccff_head   (head),
        .i_ccff_tail   (tail),
        .o_prog_clk_en (en),
        .o_busy        (busy),
        .o_done        (done),
        .o_error       (err),
        .o_bit_count   (cnt)
    );

    always #5 clk = ~clk;

    assign tail = stuck0 ? 1'b0 : chain[n_len - 4'd1];

    // Chain model on the gated programming clock plus passive monitors.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            chain <= '0;
        end else if (en) begin
            chain <= {chain[8:0], head};
        end
        if (en) begin
            head_log <= {head_log[8:0], head};
            en_cnt   <= en_cnt + 1;
        end
        if (valid && ready) xfers <= xfers + 1;
        if (busy && !en) frz_cnt <= frz_cnt + 1;
        prev_frz <= mon_on && busy && !en;
        prev_cnt <= cnt;
        if (prev_frz && cnt !== prev_cnt) frz_viol <= frz_viol + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic pm);
        start = 1'b1;
        probe = pm;
        @(negedge clk);
        start = 1'b0;
        probe = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int k;
        k = 0;
        while (!(done || err) && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk(tag, {31'd0, done || err}, 32'd1);
    endtask

    // Feeds words 0xA,0x5,0xC; optional underrun after the first word and
    // an optional stray start/probe pulse while busy.
    task automatic run_load(input int gap, input bit poke, output int span);
        int base, g, idx, c0, k;
        base = xfers;
        g    = gap;
        c0   = -1;
        pulse_start(1'b0);
        for (k = 0; k < 200 && !done && !err; k++) begin
            idx   = xfers - base;
            start = poke && (k == 3);
            probe = poke && (k == 3);
            if (en && c0 < 0) c0 = cyc;
            if (idx == 1 && g > 0) begin
                valid = 1'b0;
                if (ready) g--;
            end else if (idx < 3) begin
                valid = 1'b1;
                data  = words[idx];
            end else begin
                valid = 1'b0;
            end
            @(negedge clk);
        end
        valid = 1'b0;
        start = 1'b0;
        probe = 1'b0;
        span  = cyc - c0;
        chk("load_end_seen", {31'd0, done || err}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_en, b_x, b_f, b_v, span, k;
        words[0] = 4'hA;
        words[1] = 4'h5;
        words[2] = 4'hC;

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_head",  {31'd0, head},  32'd0);
        chk("rst_en",    {31'd0, en},    32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_busy",  {31'd0, busy},  32'd0);
        chk("rst_done",  {31'd0, done},  32'd0);
        chk("rst_err",   {31'd0, err},   32'd0);
        chk("rst_cnt",   32'(cnt),       32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Test 1: continuous load
        mon_on = 1'b1;
        b_en = en_cnt; b_x = xfers; b_f = frz_cnt; b_v = frz_viol;
        run_load(0, 1'b0, span);
        chk("t1_head_seq", 32'(head_log), 32'h297);
        chk("t1_en_cycles", 32'(en_cnt - b_en), 32'd10);
        chk("t1_transfers", 32'(xfers - b_x), 32'd3);
        chk("t1_no_bubble", 32'(span), 32'd10);
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_err",  {31'd0, err},  32'd0);
        chk("t1_cnt",  32'(cnt), 32'd10);
        chk("t1_chain", 32'(chain), 32'h297);
        @(negedge clk);
        chk("t1_busy_clear", {31'd0, busy}, 32'd0);
        chk("t1_idle_ready", {31'd0, ready}, 32'd0);
        chk("t1_stall_cycles", 32'(frz_cnt - b_f), 32'd2);
        chk("t1_freeze_viol", 32'(frz_viol - b_v), 32'd0);
        repeat (3) @(negedge clk);
        chk("t1_done_sticky", {31'd0, done}, 32'd1);

        // Test 2: underrun after the first word
        b_en = en_cnt; b_x = xfers; b_f = frz_cnt; b_v = frz_viol;
        run_load(5, 1'b0, span);
        @(negedge clk);
        chk("t2_stall_cycles", 32'(frz_cnt - b_f), 32'd7);
        chk("t2_freeze_viol", 32'(frz_viol - b_v), 32'd0);
        chk("t2_en_cycles", 32'(en_cnt - b_en), 32'd10);
        chk("t2_transfers", 32'(xfers - b_x), 32'd3);
        chk("t2_chain", 32'(chain), 32'h297);
        chk("t2_done", {31'd0, done}, 32'd1);
        chk("t2_cnt",  32'(cnt), 32'd10);
        mon_on = 1'b0;

        // Test 3: probe on a matching 10-flop chain (chain emptied by reset)
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_len = 4'd10;
        pulse_start(1'b1);
        chk("t3_busy", {31'd0, busy}, 32'd1);
        chk("t3_done_cleared", {31'd0, done}, 32'd0);
        chk("t3_first_head", {31'd0, head}, 32'd1);
        chk("t3_probe_ready", {31'd0, ready}, 32'd0);
        wait_end("t3_end_seen");
        chk("t3_done", {31'd0, done}, 32'd1);
        chk("t3_err",  {31'd0, err},  32'd0);
        chk("t3_cnt",  32'(cnt), 32'd11);
        chk("t3_chain_empty", 32'(chain), 32'd0);
        repeat (2) @(negedge clk);

        // Test 4: chain one flop short
        n_len = 4'd9;
        pulse_start(1'b1);
        wait_end("t4_end_seen");
        chk("t4_err",  {31'd0, err},  32'd1);
        chk("t4_done", {31'd0, done}, 32'd0);
        chk("t4_cnt",  32'(cnt), 32'd10);
        repeat (2) @(negedge clk);

        // Test 5: tail stuck at 0 -> timeout
        n_len  = 4'd10;
        stuck0 = 1'b1;
        pulse_start(1'b1);
        wait_end("t5_end_seen");
        chk("t5_err",  {31'd0, err},  32'd1);
        chk("t5_done", {31'd0, done}, 32'd0);
        chk("t5_cnt",  32'(cnt), 32'd14);
        chk("t5_busy_at_err", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("t5_busy_drop", {31'd0, busy}, 32'd0);
        stuck0 = 1'b0;
        repeat (2) @(negedge clk);

        // Test 6: reset mid-load, then a fresh load with a stray start while busy
        b_x = xfers;
        pulse_start(1'b0);
        k = 0;
        while (cnt != CW'(5) && k < 50) begin
            valid = 1'b1;
            data  = words[(xfers - b_x) < 3 ? (xfers - b_x) : 0];
            @(negedge clk);
            k++;
        end
        chk("t6_reached_5", 32'(cnt), 32'd5);
        rst   = 1'b1;
        valid = 1'b0;
        @(negedge clk);
        chk("t6_rst_head",  {31'd0, head},  32'd0);
        chk("t6_rst_en",    {31'd0, en},    32'd0);
        chk("t6_rst_ready", {31'd0, ready}, 32'd0);
        chk("t6_rst_busy",  {31'd0, busy},  32'd0);
        chk("t6_rst_done",  {31'd0, done},  32'd0);
        chk("t6_rst_err",   {31'd0, err},   32'd0);
        chk("t6_rst_cnt",   32'(cnt),       32'd0);
        rst = 1'b0;
        @(negedge clk);
        b_x = xfers;
        run_load(0, 1'b1, span);
        chk("t6_head_seq", 32'(head_log), 32'h297);
        chk("t6_transfers", 32'(xfers - b_x), 32'd3);
        chk("t6_done", {31'd0, done}, 32'd1);
        chk("t6_err",  {31'd0, err},  32'd0);
        chk("t6_cnt",  32'(cnt), 32'd10);
        chk("t6_chain", 32'(chain), 32'h297);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
